// File: rtl/iteration_counter.sv
// Programmable up/down iteration counter with sticky terminal flag K,
// busy status and a one-cycle done pulse.
module iteration_counter #(
    parameter int WIDTH = 3
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic             En,
    input  logic             Mode,
    input  logic [WIDTH-1:0] Limit,
    output logic [WIDTH-1:0] Count,
    output logic             Busy,
    output logic             K,
    output logic             Done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             mode_q, mode_d;
    logic             k_q, k_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] term;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            count_q <= '0;
            limit_q <= '0;
            mode_q  <= 1'b0;
            k_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            limit_q <= limit_d;
            mode_q  <= mode_d;
            k_q     <= k_d;
            done_q  <= done_d;
        end
    end

    // Step value and terminal come from the latched mode, never the live inputs.
    assign step = mode_q ? count_q - 1'b1 : count_q + 1'b1;
    assign term = mode_q ? '0 : limit_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        limit_d = limit_q;
        mode_d  = mode_q;
        k_d     = k_q;
        done_d  = 1'b0;
        if (Start) begin
            limit_d = Limit;
            mode_d  = Mode;
            count_d = Mode ? Limit : '0;
            if (Limit == '0) begin
                state_d = DONE;
                k_d     = 1'b1;
                done_d  = 1'b1;
            end else begin
                state_d = COUNT;
                k_d     = 1'b0;
            end
        end else begin
            unique case (state_q)
                COUNT: begin
                    if (En) begin
                        count_d = step;
                        if (step == term) begin
                            state_d = DONE;
                            k_d     = 1'b1;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign Count = count_q;
    assign Busy  = (state_q == COUNT);
    assign K     = k_q;
    assign Done  = done_q;

endmodule
